// File: rtl/video_mon_pkg.sv
// Shared constants and types for the ULA video frame monitor and related checkers.
package video_mon_pkg;

  // Expected line length in pixel samples for each machine timing
  localparam int LINE_LEN_48  = 448;
  localparam int LINE_LEN_128 = 456;

  // Expected lines per frame for each machine timing
  localparam int LINES_48     = 312;
  localparam int LINES_128    = 311;

  // CRC-16/CCITT generator polynomial, non-reflected
  localparam logic [15:0] CRC_POLY = 16'h1021;

  // Monitor sequencing: idle until a frame boundary, then measure continuously
  typedef enum logic {
    WAIT_VS,
    MEASURE
  } mon_state_t;

endpackage

// File: rtl/video_frame_monitor_if.sv
// ULA video output stream: sync, blanking and colour, qualified by the pixel enable.
interface video_frame_monitor_if;

  logic       ce_vid;
  logic       HSync;
  logic       VSync;
  logic       HBlank;
  logic [2:0] Rx;
  logic [2:0] Gx;
  logic [2:0] Bx;

  // The ULA (or a bench) drives the stream
  modport master (
    output ce_vid, HSync, VSync, HBlank, Rx, Gx, Bx
  );

  // Passive observers only listen
  modport slave (
    input ce_vid, HSync, VSync, HBlank, Rx, Gx, Bx
  );

endinterface

// File: rtl/crc16_9b.sv
// CRC-16/CCITT (poly 0x1021, non-reflected) advanced by one 9-bit colour word.
// The nine serial MSB-first steps are unrolled into a single combinational update.
module crc16_9b
  import video_mon_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [8:0]  d,
  output logic [15:0] crc_out
);

  // Unrolled LFSR: bit 8 of d enters first
  always_comb begin
    crc_out = crc_in;
    for (int i = 8; i >= 0; i--) begin
      if (crc_out[15] ^ d[i]) begin
        crc_out = {crc_out[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_out = {crc_out[14:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/video_frame_monitor.sv
// Passive frame monitor for the ULA video stream: measures line length, lines per
// frame and active pixels per line, signs every complete frame with a CRC, and
// flags timing that does not match the selected 48K/128K machine.
module video_frame_monitor
  import video_mon_pkg::*;
#(
  parameter logic [15:0] CRC_INIT = 16'hFFFF,
  parameter int          SAT_MAX  = 1023
) (
  input  logic                 clk_sys,
  input  logic                 nRESET,
  input  logic                 m128,
  video_frame_monitor_if.slave vid,
  output logic [9:0]           line_len,
  output logic [9:0]           frame_lines,
  output logic [9:0]           active_px,
  output logic [15:0]          frame_crc,
  output logic                 frame_done,
  output logic                 err_line,
  output logic                 err_frame,
  output logic                 locked
);

  localparam logic [9:0] SAT = 10'(SAT_MAX);

  // Counters stick at SAT instead of wrapping so a runaway line or frame stays visible
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v >= SAT) ? SAT : v + 10'd1;
  endfunction

  function automatic logic [10:0] exp_line_len(input logic mode);
    return mode ? 11'(LINE_LEN_128) : 11'(LINE_LEN_48);
  endfunction

  function automatic logic [9:0] exp_lines(input logic mode);
    return mode ? 10'(LINES_128) : 10'(LINES_48);
  endfunction

  mon_state_t  state;
  logic        hs_p1;
  logic        vs_p1;
  logic        hs_seen;
  logic [9:0]  pix_cnt;
  logic [9:0]  act_cnt;
  logic [9:0]  line_cnt;
  logic [15:0] crc_acc;

  logic        hs_rise;
  logic        vs_rise;
  logic        active;
  logic [8:0]  pixel;
  logic [10:0] pix_len;
  logic [9:0]  line_closed;
  logic [15:0] crc_src;
  logic [15:0] crc_upd;

  // Edges are judged only between consecutive enabled samples
  assign hs_rise = vid.ce_vid & vid.HSync & ~hs_p1;
  assign vs_rise = vid.ce_vid & vid.VSync & ~vs_p1;
  assign active  = ~vid.HBlank;
  assign pixel   = {vid.Rx, vid.Gx, vid.Bx};

  // Length of the line being closed, one wider than the counter so a saturated
  // line can never alias onto a legal length
  assign pix_len = {1'b0, pix_cnt} + 11'd1;

  // Line count after a coincident HSync close, so a frame end includes that line
  assign line_closed = hs_rise ? sat_inc(line_cnt) : line_cnt;

  // A frame boundary sample starts the new frame's CRC from the seed
  assign crc_src = vs_rise ? CRC_INIT : crc_acc;

  crc16_9b u_crc (
    .crc_in  (crc_src),
    .d       (pixel),
    .crc_out (crc_upd)
  );

  // ---- stage p1: previous enabled sample of the sync lines ----
  // Hold last sampled sync levels; non-enabled cycles are invisible
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      hs_p1 <= 1'b0;
      vs_p1 <= 1'b0;
    end else if (vid.ce_vid) begin
      hs_p1 <= vid.HSync;
      vs_p1 <= vid.VSync;
    end
  end

  // Running frame CRC over active samples; always reseeded before it is published
  always_ff @(posedge clk_sys) begin
    if (vs_rise) begin
      crc_acc <= active ? crc_upd : CRC_INIT;
    end else if (vid.ce_vid && active) begin
      crc_acc <= crc_upd;
    end
  end

  // ---- stage p1 -> results: sequencing, counters and published measurements ----
  // Frame/line state machine with registered result outputs
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state       <= WAIT_VS;
      hs_seen     <= 1'b0;
      pix_cnt     <= '0;
      act_cnt     <= '0;
      line_cnt    <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      active_px   <= '0;
      frame_crc   <= '0;
      frame_done  <= 1'b0;
      err_line    <= 1'b0;
      err_frame   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        WAIT_VS: begin
          // The boundary sample itself belongs to the first measured frame
          if (vs_rise) begin
            state    <= MEASURE;
            hs_seen  <= 1'b0;
            pix_cnt  <= '0;
            act_cnt  <= {9'd0, active};
            line_cnt <= '0;
          end
        end

        MEASURE: begin
          if (vid.ce_vid) begin
            if (hs_rise) begin
              // Close the line; the first close after entry covers a partial line
              pix_cnt  <= '0;
              act_cnt  <= {9'd0, active};
              line_cnt <= sat_inc(line_cnt);
              hs_seen  <= 1'b1;
              if (hs_seen) begin
                line_len  <= sat_inc(pix_cnt);
                active_px <= act_cnt;
                if (pix_len != exp_line_len(m128)) begin
                  err_line <= 1'b1;
                end
              end
            end else begin
              pix_cnt <= sat_inc(pix_cnt);
              if (active) begin
                act_cnt <= sat_inc(act_cnt);
              end
            end

            if (vs_rise) begin
              // Close the frame after any coincident line close, then restart
              frame_lines <= line_closed;
              frame_crc   <= crc_acc;
              frame_done  <= 1'b1;
              locked      <= 1'b1;
              if ((line_closed != exp_lines(m128)) || (line_closed == SAT)) begin
                err_frame <= 1'b1;
              end
              pix_cnt  <= '0;
              act_cnt  <= {9'd0, active};
              line_cnt <= '0;
            end
          end
        end

        default: state <= WAIT_VS;
      endcase
    end
  end

endmodule

// File: tb/tb_video_frame_monitor.sv
// Scoreboard bench for video_frame_monitor: frames are described at line level,
// expected per-frame results are derived from that description and queued, and a
// monitor pops and compares them whenever frame_done pulses.
module tb_video_frame_monitor;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam int          SAT      = 1023;

  typedef struct {
    int n_lines;
    int len;
    int act;
  } frame_t;

  typedef struct {
    logic [9:0]  ll;
    logic [9:0]  fl;
    logic [9:0]  ap;
    logic [15:0] crc;
    logic        el;
    logic        ef;
    logic        lk;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        nRESET;
  logic        m128;
  logic [9:0]  line_len;
  logic [9:0]  frame_lines;
  logic [9:0]  active_px;
  logic [15:0] frame_crc;
  logic        frame_done;
  logic        err_line;
  logic        err_frame;
  logic        locked;

  video_frame_monitor_if vid ();

  video_frame_monitor #(
    .CRC_INIT (CRC_INIT),
    .SAT_MAX  (SAT)
  ) dut (
    .clk_sys     (clk_sys),
    .nRESET      (nRESET),
    .m128        (m128),
    .vid         (vid),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .active_px   (active_px),
    .frame_crc   (frame_crc),
    .frame_done  (frame_done),
    .err_line    (err_line),
    .err_frame   (err_frame),
    .locked      (locked)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          n_done = 0;
  exp_t        sb[$];
  exp_t        e_mon;
  frame_t      plan[$];
  bit          pix_bits[$];
  logic [15:0] crc_hist[$];
  logic        m_el;
  logic        m_ef;
  int          gap_lo;
  int          gap_hi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // CRC-16/CCITT of the frame's active colour bits, taken as one serial message
  function automatic logic [15:0] crc_of_bits();
    logic [15:0] r;
    logic        top;
    r = CRC_INIT;
    foreach (pix_bits[i]) begin
      top = r[15] ^ pix_bits[i];
      r   = {r[14:0], 1'b0};
      if (top) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Monitor: one expected record per frame_done pulse
  always @(negedge clk_sys) begin
    if (frame_done === 1'b1) begin
      n_done++;
      crc_hist.push_back(frame_crc);
      if (sb.size() == 0) begin
        check("expected_frame_pending", sb.size(), 1);
      end else begin
        e_mon = sb.pop_front();
        check("line_len",    line_len,    e_mon.ll);
        check("frame_lines", frame_lines, e_mon.fl);
        check("active_px",   active_px,   e_mon.ap);
        check("frame_crc",   frame_crc,   e_mon.crc);
        check("err_line",    err_line,    e_mon.el);
        check("err_frame",   err_frame,   e_mon.ef);
        check("locked",      locked,      e_mon.lk);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_line_len"},    line_len,    0);
    check({tag, "_frame_lines"}, frame_lines, 0);
    check({tag, "_active_px"},   active_px,   0);
    check({tag, "_frame_crc"},   frame_crc,   0);
    check({tag, "_frame_done"},  frame_done,  0);
    check({tag, "_err_line"},    err_line,    0);
    check({tag, "_err_frame"},   err_frame,   0);
    check({tag, "_locked"},      locked,      0);
  endtask

  task automatic idle_inputs();
    vid.ce_vid = 1'b0;
    vid.HSync  = 1'b0;
    vid.VSync  = 1'b0;
    vid.HBlank = 1'b1;
    vid.Rx     = 3'd0;
    vid.Gx     = 3'd0;
    vid.Bx     = 3'd0;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    nRESET = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk_sys);
    check_zero("reset");
    nRESET = 1'b1;
  endtask

  task automatic add_frame(input int n, input int len, input int act);
    frame_t fr;
    fr.n_lines = n;
    fr.len     = len;
    fr.act     = act;
    plan.push_back(fr);
  endtask

  // One enabled sample, preceded by disabled cycles carrying random garbage
  task automatic put_sample(input logic hs, input logic vs, input logic hb, input logic [8:0] px);
    int gap;
    gap = (gap_hi == 0) ? 0 : int'($urandom_range(gap_hi, gap_lo));
    repeat (gap) begin
      @(negedge clk_sys);
      vid.ce_vid = 1'b0;
      vid.HSync  = 1'($urandom);
      vid.VSync  = 1'($urandom);
      vid.HBlank = 1'($urandom);
      vid.Rx     = 3'($urandom);
      vid.Gx     = 3'($urandom);
      vid.Bx     = 3'($urandom);
    end
    @(negedge clk_sys);
    vid.ce_vid = 1'b1;
    vid.HSync  = hs;
    vid.VSync  = vs;
    vid.HBlank = hb;
    vid.Rx     = px[8:6];
    vid.Gx     = px[5:3];
    vid.Bx     = px[2:0];
  endtask

  // Expected results for plan frame f, closed by the first sample of frame f+1
  task automatic push_expect(input int f, input logic mode);
    exp_t e;
    int   n, len, act, closes;
    n      = plan[f].n_lines;
    len    = plan[f].len;
    act    = plan[f].act;
    closes = (f == 0) ? n - 1 : n;
    if (closes > 0 && len != (mode ? 456 : 448)) m_el = 1'b1;
    if (n >= SAT || n != (mode ? 311 : 312)) m_ef = 1'b1;
    e.ll  = 10'((len > SAT) ? SAT : len);
    e.fl  = 10'((n > SAT) ? SAT : n);
    e.ap  = 10'((act > SAT) ? SAT : act);
    e.crc = crc_of_bits();
    e.el  = m_el;
    e.ef  = m_ef;
    e.lk  = 1'b1;
    sb.push_back(e);
  endtask

  task automatic mid_reset();
    @(posedge clk_sys);
    #2;
    nRESET = 1'b0;
    idle_inputs();
    #1 check_zero("midreset_async");
    @(posedge clk_sys);
    #1 check_zero("midreset_next_clk");
    check("midreset_sb_empty", sb.size(), 0);
    repeat (3) @(negedge clk_sys);
    nRESET = 1'b1;
  endtask

  // Drive every frame in plan: sync at the start of each line, VSync on line 0,
  // active pixels from sample 3; the last frame is left open
  task automatic run_plan(input logic mode, input int g_lo, input int g_hi,
                          input bit zero_px, input bit with_reset, input int abort_at);
    int         base_done, sent, n, len, act;
    logic       hs, vs, hb;
    logic [8:0] px;
    if (with_reset) do_reset();
    m128      = mode;
    gap_lo    = g_lo;
    gap_hi    = g_hi;
    m_el      = 1'b0;
    m_ef      = 1'b0;
    base_done = n_done;
    sent      = 0;
    sb.delete();
    for (int f = 0; f < plan.size(); f++) begin
      if (f > 0) push_expect(f - 1, mode);
      if (f == 1) check("locked_before_first_frame", locked, 0);
      pix_bits.delete();
      n   = plan[f].n_lines;
      len = plan[f].len;
      act = plan[f].act;
      for (int l = 0; l < n; l++) begin
        for (int s = 0; s < len; s++) begin
          if (abort_at >= 0 && sent == abort_at) begin
            mid_reset();
            plan.delete();
            return;
          end
          hs = (s < 2);
          vs = (l == 0) && (s < 2);
          hb = !((s >= 3) && (s < 3 + act));
          px = zero_px ? 9'd0 : 9'($urandom);
          if (!hb) begin
            for (int b = 8; b >= 0; b--) pix_bits.push_back(px[b]);
          end
          put_sample(hs, vs, hb, px);
          sent++;
        end
      end
    end
    @(negedge clk_sys);
    idle_inputs();
    repeat (4) @(negedge clk_sys);
    check("frame_done_count", n_done - base_done, plan.size() - 1);
    check("scoreboard_drained", sb.size(), 0);
    plan.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf, ln, lp;
    nRESET = 1'b0;
    m128   = 1'b0;
    gap_lo = 0;
    gap_hi = 0;
    idle_inputs();
    repeat (2) @(negedge clk_sys);
    check_zero("power_on");

    // 48K-length lines, short frames: no line error, frame count error
    repeat (3) add_frame(3, 448, 256);
    run_plan(1'b0, 0, 0, 1'b0, 1'b1, -1);

    // Same stream judged against 128K timing
    repeat (3) add_frame(3, 448, 256);
    run_plan(1'b1, 0, 0, 1'b0, 1'b1, -1);

    // 128K-length lines under 128K timing
    repeat (3) add_frame(2, 456, 200);
    run_plan(1'b1, 0, 1, 1'b0, 1'b1, -1);

    // Full 312-line frames with coincident HSync/VSync at each boundary
    repeat (3) add_frame(312, 6, 2);
    run_plan(1'b0, 0, 0, 1'b0, 1'b1, -1);

    // Full 311-line frames under 128K timing
    repeat (2) add_frame(311, 6, 3);
    run_plan(1'b1, 0, 0, 1'b0, 1'b1, -1);

    // Enable every 8th clock with garbage between enables
    repeat (3) add_frame(4, 12, 7);
    run_plan(1'b0, 7, 7, 1'b0, 1'b1, -1);

    // 500-line frame: counts without saturating
    add_frame(4, 8, 4);
    add_frame(500, 8, 5);
    add_frame(2, 8, 4);
    run_plan(1'b0, 0, 0, 1'b0, 1'b1, -1);

    // Frame with one 2000-sample line: pixel and active counters saturate
    add_frame(3, 10, 5);
    add_frame(1, 2000, 1997);
    add_frame(2, 10, 5);
    run_plan(1'b0, 0, 0, 1'b0, 1'b1, -1);

    // Constant black on 256 active samples: identical CRC every frame
    repeat (4) add_frame(3, 300, 256);
    crc_hist.delete();
    run_plan(1'b0, 0, 0, 1'b1, 1'b1, -1);
    if (crc_hist.size() == 3) begin
      check("crc_repeat_a", crc_hist[1], crc_hist[0]);
      check("crc_repeat_b", crc_hist[2], crc_hist[1]);
    end else begin
      check("crc_hist_size", crc_hist.size(), 3);
    end

    // Asynchronous reset in the middle of the second frame
    repeat (3) add_frame(3, 20, 10);
    run_plan(1'b0, 0, 1, 1'b0, 1'b1, 3 * 20 + 25);
    repeat (3) add_frame(3, 20, 10);
    run_plan(1'b0, 0, 1, 1'b0, 1'b0, -1);

    // Randomised frame shapes, modes and enable gaps
    for (int k = 0; k < 4; k++) begin
      nf = int'($urandom_range(4, 2));
      for (int f = 0; f < nf; f++) begin
        ln = int'($urandom_range(6, 2));
        lp = int'($urandom_range(40, 6));
        add_frame(ln, lp, int'($urandom_range(lp - 3, 0)));
      end
      run_plan(1'($urandom), 0, int'($urandom_range(3, 0)), 1'b0, 1'b1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_frame_monitor.md
# video_frame_monitor

Passive monitor on the ULA video output (HSync, VSync, HBlank, Rx/Gx/Bx, qualified by ce_vid). It measures line length, lines per frame and active pixels per line, and computes a CRC over every active pixel of each complete frame. It reports the results and any timing violations once per frame. It sits beside the ULA in simulation benches and in the MiST debug build, and consumes the stream the ULA produces.

## Interface

Parameters:
- CRC_INIT, 16'hFFFF, CRC seed loaded at each frame start.
- SAT_MAX, 1023, saturation value of every counter (10-bit).

Ports:
- clk_sys  in  1  master clock; all logic runs here.
- nRESET  in  1  asynchronous, active-low reset.
- ce_vid  in  1  pixel clock enable. Samples are taken only when ce_vid=1.
- m128  in  1  expected timing select. 0 = 48K (448 clocks/line, 312 lines). 1 = 128K (456 clocks/line, 311 lines).
- HSync, VSync, HBlank  in  1 each  active-high, from the ULA.
- Rx, Gx, Bx  in  3 each  pixel colour.
- line_len  out  10  clocks between the last two HSync rising edges.
- frame_lines  out  10  lines in the last complete frame.
- active_px  out  10  HBlank=0 samples in the last complete line.
- frame_crc  out  16  CRC of the last complete frame.
- frame_done  out  1  one-clk_sys pulse when the outputs above update for a frame.
- err_line  out  1  sticky: a line_len differed from the expected value.
- err_frame  out  1  sticky: a frame_lines value differed from the expected value.
- locked  out  1  at least one complete frame has been measured.

## Operation

- **Edge detection.** Registered copies of HSync and VSync are updated on ce_vid samples only. A rise is current=1 while previous=0, evaluated on the same ce_vid sample.
- **States:**
  - WAIT_VS (reset state): ignore all input until a VSync rise, then go to MEASURE.
  - MEASURE:
    - Count pixels (pix_cnt), lines (line_cnt) and active samples (act_cnt).
    - Update the CRC on each sample with HBlank=0.
    - On the next VSync rise, publish the results, pulse frame_done, set locked, reload all counters and the CRC, and stay in MEASURE.
- **Line handling (MEASURE).** On an HSync rise:
  - line_len <= pix_cnt+1 and active_px <= act_cnt.
  - pix_cnt and act_cnt restart.
  - line_cnt increments.
  - err_line is set if pix_cnt+1 ≠ (m128 ? 456 : 448).
  - The first HSync rise after entering MEASURE starts counting and performs no length check, because that line is partial.
- **Frame handling.** On a VSync rise, frame_lines <= line_cnt and err_frame is set if line_cnt ≠ (m128 ? 311 : 312). The first frame after WAIT_VS is the first complete frame.
- **CRC.** CRC-16/CCITT, polynomial 0x1021, non-reflected. The 9-bit value {Rx,Gx,Bx} is shifted in MSB-first, as a single-cycle parallel update of 9 serial steps.
- **Saturation.** All counters saturate at SAT_MAX and never wrap. A saturated line_cnt forces err_frame at the frame end.
- **Simultaneous events.** When HSync and VSync rise on the same sample, the HSync processing (line close) happens first, then the VSync processing. frame_lines therefore includes the line that just closed.
- **Mode change.** A change of m128 takes effect at the next comparison. Sticky error flags are cleared only by reset.

## Timing

- Reset values: every output is 0 and the state is WAIT_VS.
- An asynchronous assert of nRESET mid-frame abandons the frame, and no frame_done is produced for it.
- Results appear 1 clk_sys after the ce_vid sample that carries the edge. frame_done is high for that same cycle only.
- Inputs are sampled only when ce_vid=1. Glitches between enables are invisible to the monitor.
- Throughput: one sample per clk_sys is supported. ce_vid may be held at 1 continuously.

## Structure

- The package video_mon_pkg holds:
  - LINE_LEN_48=448, LINE_LEN_128=456, LINES_48=312, LINES_128=311;
  - CRC_POLY=16'h1021;
  - a state enum {WAIT_VS, MEASURE}.
- Sub-module crc16_9b: combinational function of (crc_in[15:0], d[8:0]) returning crc_out. It is reusable by other video checkers.
- The rest (edge detectors, counters, result registers) is flat in video_frame_monitor.

## Test plan

- 48K stream, ce_vid every 8th clk_sys, 448-clock lines, 312 lines, 3 frames → frame_done pulses twice (frames 2 and 3), frame_lines=312, line_len=448, err_line=err_frame=0, locked=1 after the first pulse.
- Same stream with m128=1 → err_line=1 at the first full line, err_frame=1 at the first frame end.
- Constant colour {Rx,Gx,Bx}=9'h000 on 256 active samples per line → frame_crc equals the crc16_9b reference model value, and is identical in consecutive frames.
- HSync and VSync rising on the same sample → frame_lines counts the closing line (312, not 311).
- Injected 500-line frame → line_cnt reaches 500 without saturating, and err_frame=1. Injected no-HSync frame with ce_vid held at 1 for 2000 clocks → pix_cnt holds at 1023 and does not wrap.
- nRESET asserted mid-frame → all outputs 0 on the next clock, no frame_done until a full frame completes after the next VSync rise.
